lieat_exu_div: RTL and testbench

- Iterative radix-2 non-restoring integer divider in the EXU, the inverse counterpart of the iterative multiplier.
- Serves DIV/DIVU/REM/REMU with RISC-V-exact corner-case results.
- Uses the same valid/ready in/out handshake as the multiplier, so the EXU dispatch can drive either unit identically.
- Returns quotient and remainder together.

---
 rtl/lieat_exu_div_pkg.sv | 37 +++
 rtl/lieat_exu_div_step.sv | 27 ++
 rtl/lieat_exu_div.sv | 179 +++++++++++++++++
 tb/tb_lieat_exu_div.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lieat_exu_div_pkg.sv
// Shared definitions for the iterative radix-2 non-restoring divider.
// Optional feature macro: LIEAT_DIV_SHORTCUT_EN (early exit when |dividend| < |divisor|).
package lieat_exu_div_pkg;

  // Operand/result width; the divider iterates once per bit.
  localparam int XLEN      = 32;
  localparam int DIV_CNT_W = 6;

  // Bit positions of the one-hot state vector.
  localparam int ST_IDLE_BIT = 0;
  localparam int ST_CYC_BIT  = 1;
  localparam int ST_FIX_BIT  = 2;
  localparam int ST_OUT_BIT  = 3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_CYC  = 4'b0010,
    ST_FIX  = 4'b0100,
    ST_OUT  = 4'b1000
  } div_state_e;

  // Divide-by-zero quotient and the one dividend that can overflow a signed divide.
  localparam logic [XLEN-1:0] DIV_ZERO_QUOT = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] DIV_OVF_DVD   = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement magnitude of v when neg is set.
  function automatic logic [XLEN-1:0] div_abs(input logic [XLEN-1:0] v, input logic neg);
    logic [XLEN-1:0] r;
    if (neg) begin
      r = (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/lieat_exu_div_step.sv
// One combinational non-restoring division iteration on {P,Q}.
// Kept stand-alone so two copies can be chained for a radix-4 variant.
module lieat_exu_div_step
  import lieat_exu_div_pkg::*;
(
  input  logic [XLEN:0]   p_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN:0]   p_o,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN:0] p_sh_s;

  // Shift {P,Q} left, then subtract or add the divisor depending on the old sign of P.
  // Intermediate values may wrap, but the result always lies in [-D, D) and fits XLEN+1 bits.
  always_comb begin
    p_sh_s = {p_i[XLEN-1:0], q_i[XLEN-1]};
    if (p_i[XLEN] == 1'b0) begin
      p_o = p_sh_s - {1'b0, dvs_i};
    end else begin
      p_o = p_sh_s + {1'b0, dvs_i};
    end
    q_o = {q_i[XLEN-2:0], ~p_o[XLEN]};
  end

endmodule

// File: rtl/lieat_exu_div.sv
// Iterative radix-2 non-restoring divider for DIV/DIVU/REM/REMU.
// Optional feature macro: LIEAT_DIV_SHORTCUT_EN. When defined, requests with
// |dividend| < |divisor| complete in one clock; results are identical either way.
module lieat_exu_div
  import lieat_exu_div_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            div_i_valid,
  output logic            div_i_ready,
  input  logic            div_i_signed,
  input  logic [XLEN-1:0] div_i_dividend,
  input  logic [XLEN-1:0] div_i_divisor,
  output logic            div_o_valid,
  input  logic            div_o_ready,
  output logic [XLEN-1:0] div_o_quot,
  output logic [XLEN-1:0] div_o_rem
);

  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(XLEN - 1);
  localparam logic [DIV_CNT_W-1:0] CNT_ONE  = DIV_CNT_W'(1);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]        p_q, p_d;
  logic [XLEN-1:0]      q_q, q_d;
  logic [XLEN-1:0]      dvs_q, dvs_d;
  logic                 quot_neg_q, quot_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]      quot_q, quot_d;
  logic [XLEN-1:0]      rem_q, rem_d;

  logic                 accept_s;
  logic                 neg_dvd_s, neg_dvs_s;
  logic [XLEN-1:0]      abs_dvd_s, abs_dvs_s;
  logic                 dvz_s, ovf_s, short_s;
  logic [XLEN:0]        p_step_s, p_fix_s;
  logic [XLEN-1:0]      q_step_s;

  // Handshake flags come straight from registered state bits.
  assign div_i_ready = state_q[ST_IDLE_BIT];
  assign div_o_valid = state_q[ST_OUT_BIT];
  assign div_o_quot  = quot_q;
  assign div_o_rem   = rem_q;

  assign accept_s  = div_i_valid & div_i_ready;
  assign neg_dvd_s = div_i_signed & div_i_dividend[XLEN-1];
  assign neg_dvs_s = div_i_signed & div_i_divisor[XLEN-1];
  assign abs_dvd_s = div_abs(div_i_dividend, neg_dvd_s);
  assign abs_dvs_s = div_abs(div_i_divisor, neg_dvs_s);
  assign dvz_s     = (div_i_divisor == {XLEN{1'b0}});
  assign ovf_s     = div_i_signed & (div_i_dividend == DIV_OVF_DVD) &
                     (div_i_divisor == {XLEN{1'b1}});

`ifdef LIEAT_DIV_SHORTCUT_EN
  assign short_s = (abs_dvd_s < abs_dvs_s) & ~dvz_s;
`else
  assign short_s = 1'b0;
`endif

  lieat_exu_div_step u_step (
    .p_i   (p_q),
    .q_i   (q_q),
    .dvs_i (dvs_q),
    .p_o   (p_step_s),
    .q_o   (q_step_s)
  );

  // Final remainder restore: a negative partial remainder gets |divisor| added back.
  always_comb begin
    if (p_q[XLEN] == 1'b1) begin
      p_fix_s = p_q + {1'b0, dvs_q};
    end else begin
      p_fix_s = p_q;
    end
  end

  // Next-state and datapath update for IDLE/CYC/FIX/OUT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    q_d        = q_q;
    dvs_d      = dvs_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          dvs_d      = abs_dvs_s;
          quot_neg_d = neg_dvd_s ^ neg_dvs_s;
          rem_neg_d  = neg_dvd_s;
          cnt_d      = {DIV_CNT_W{1'b0}};
          p_d        = {(XLEN+1){1'b0}};
          q_d        = abs_dvd_s;
          if (dvz_s) begin
            state_d = ST_OUT;
            quot_d  = DIV_ZERO_QUOT;
            rem_d   = div_i_dividend;
          end else if (ovf_s) begin
            state_d = ST_OUT;
            quot_d  = DIV_OVF_DVD;
            rem_d   = {XLEN{1'b0}};
          end else if (short_s) begin
            state_d = ST_OUT;
            quot_d  = {XLEN{1'b0}};
            rem_d   = div_i_dividend;
          end else begin
            state_d = ST_CYC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CYC: begin
        p_d = p_step_s;
        q_d = q_step_s;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
          cnt_d   = {DIV_CNT_W{1'b0}};
        end else begin
          state_d = ST_CYC;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_FIX: begin
        state_d = ST_OUT;
        if (quot_neg_q) begin
          quot_d = (~q_q) + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
          quot_d = q_q;
        end
        if (rem_neg_q) begin
          rem_d = (~p_fix_s[XLEN-1:0]) + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
          rem_d = p_fix_s[XLEN-1:0];
        end
      end
      ST_OUT: begin
        if (div_o_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, datapath and result registers; reset discards any work in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {DIV_CNT_W{1'b0}};
      p_q        <= {(XLEN+1){1'b0}};
      q_q        <= {XLEN{1'b0}};
      dvs_q      <= {XLEN{1'b0}};
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      quot_q     <= {XLEN{1'b0}};
      rem_q      <= {XLEN{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      q_q        <= q_d;
      dvs_q      <= dvs_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
    end
  end

endmodule

// File: tb/tb_lieat_exu_div.sv
// Directed + random bench for lieat_exu_div with an expected-result scoreboard.
// Latency expectations follow LIEAT_DIV_SHORTCUT_EN when that macro is defined.
module tb_lieat_exu_div;

  logic        clock;
  logic        reset;
  logic        div_i_valid;
  logic        div_i_ready;
  logic        div_i_signed;
  logic [31:0] div_i_dividend;
  logic [31:0] div_i_divisor;
  logic        div_o_valid;
  logic        div_o_ready;
  logic [31:0] div_o_quot;
  logic [31:0] div_o_rem;

  typedef struct {
    logic [31:0] quot;
    logic [31:0] rem;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  lieat_exu_div dut (
    .clock          (clock),
    .reset          (reset),
    .div_i_valid    (div_i_valid),
    .div_i_ready    (div_i_ready),
    .div_i_signed   (div_i_signed),
    .div_i_dividend (div_i_dividend),
    .div_i_divisor  (div_i_divisor),
    .div_o_valid    (div_o_valid),
    .div_o_ready    (div_o_ready),
    .div_o_quot     (div_o_quot),
    .div_o_rem      (div_o_rem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results, RISC-V semantics.
  task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  function automatic int exp_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef LIEAT_DIV_SHORTCUT_EN
    logic [31:0] aa;
    logic [31:0] ab;
`endif
    if (b == 32'd0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef LIEAT_DIV_SHORTCUT_EN
    aa = (sgn && a[31]) ? -a : a;
    ab = (sgn && b[31]) ? -b : b;
    if (aa < ab) return 1;
`endif
    return 34;
  endfunction

  // One request/response transaction; hold = cycles of output backpressure.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    exp_t        e;
    logic [31:0] mq;
    logic [31:0] mr;
    logic [31:0] oq;
    logic [31:0] orr;
    int          lat;
    logic        busy_ok;
    logic        stable_ok;
    model(sgn, a, b, mq, mr);
    e.quot = mq;
    e.rem  = mr;
    e.lat  = exp_lat(sgn, a, b);
    sb.push_back(e);

    @(negedge clock);
    check({tag, ".ready_in_idle"}, {31'd0, div_i_ready}, 32'd1);
    div_i_valid    = 1'b1;
    div_i_signed   = sgn;
    div_i_dividend = a;
    div_i_divisor  = b;
    div_o_ready    = (hold == 0);
    @(posedge clock);
    #1;
    // Keep a junk request pending while busy; it must not be taken.
    div_i_signed   = ~sgn;
    div_i_dividend = $urandom();
    div_i_divisor  = $urandom();
    lat     = 1;
    busy_ok = 1'b1;
    while (div_o_valid !== 1'b1 && lat < 100) begin
      if (div_i_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clock);
      #1;
      lat++;
    end
    div_i_valid = 1'b0;
    check({tag, ".busy_not_ready"}, {31'd0, busy_ok}, 32'd1);
    check({tag, ".valid_seen"}, {31'd0, div_o_valid}, 32'd1);
    check({tag, ".ready_in_out"}, {31'd0, div_i_ready}, 32'd0);

    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".latency"}, lat, e.lat);
      check({tag, ".quot"}, div_o_quot, e.quot);
      check({tag, ".rem"}, div_o_rem, e.rem);
    end else begin
      check({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
    end

    if (hold > 0) begin
      oq        = div_o_quot;
      orr       = div_o_rem;
      stable_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clock);
        #1;
        if (div_o_valid !== 1'b1 || div_o_quot !== oq || div_o_rem !== orr) stable_ok = 1'b0;
      end
      check({tag, ".held_stable"}, {31'd0, stable_ok}, 32'd1);
      div_o_ready = 1'b1;
    end
    @(posedge clock);
    #1;
    check({tag, ".released_idle"}, {30'd0, div_o_valid, div_i_ready}, 32'd1);
  endtask

  initial begin
    logic        rs;
    logic [31:0] ra;
    logic [31:0] rb;
    reset          = 1'b0;
    div_i_valid    = 1'b0;
    div_i_signed   = 1'b0;
    div_i_dividend = 32'd0;
    div_i_divisor  = 32'd0;
    div_o_ready    = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset.ready", {31'd0, div_i_ready}, 32'd1);
    check("reset.valid", {31'd0, div_o_valid}, 32'd0);
    check("reset.quot", div_o_quot, 32'd0);
    check("reset.rem", div_o_rem, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    run_op("s100_7", 1'b1, 32'd100, 32'd7, 0);
    run_op("sneg100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 0);
    run_op("uffff_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("s1234_0", 1'b1, 32'h0000_1234, 32'd0, 0);
    run_op("u_div0", 1'b0, 32'h8000_0001, 32'd0, 0);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("u_nonovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("s_neg_neg", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);
    run_op("bp_50_6", 1'b1, 32'd50, 32'hFFFF_FFFA, 5);
    run_op("b2b_77_8", 1'b0, 32'd77, 32'd8, 0);
    run_op("s5_9", 1'b1, 32'd5, 32'd9, 0);
    run_op("s0_5", 1'b1, 32'd0, 32'd5, 0);
    run_op("sneg3_7", 1'b1, 32'hFFFF_FFFD, 32'd7, 0);

    // Abort a divide mid-iteration with reset.
    @(negedge clock);
    div_i_valid    = 1'b1;
    div_i_signed   = 1'b0;
    div_i_dividend = 32'd1000;
    div_i_divisor  = 32'd7;
    @(posedge clock);
    #1;
    div_i_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("midrst.valid", {31'd0, div_o_valid}, 32'd0);
    check("midrst.ready", {31'd0, div_i_ready}, 32'd1);
    check("midrst.quot", div_o_quot, 32'd0);
    check("midrst.rem", div_o_rem, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_op("after_rst_9_3", 1'b0, 32'd9, 32'd3, 0);

    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom();
      rb = (i == 2) ? 32'(rb >> 20) : $urandom();
      if (i == 4) rb = 32'(ra[7:0]) + 32'd1;
      run_op($sformatf("rand%0d", i), rs, ra, rb, i % 2);
    end

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
